execute_stage: RTL
==================

Name: execute_stage

Overview:
- Execute stage of the 16-bit five-stage pipeline; consumes the registered decode/execute bundle (operands, ALU select, control bits, destination, flush tag).
- Computes the ALU result and owns the condition-code register (CCR).
- Resolves conditional jumps and raises a flush to the front end.
- Registers everything the memory stage needs into the execute/memory boundary, updated on the falling clock edge like the other stage buffers.

Parameters:
- WIDTH, 16, datapath width of operands and result.
- SHAMT_W, 4, number of low immediate bits used as the shift amount.

Ports:
- Clk  in  1  pipeline clock; all state updates on negedge Clk.
- Rst  in  1  asynchronous active-low reset: clears all state immediately on assertion, independent of Clk.
- Reg1In  in  WIDTH  operand A (Rsrc / Rdst value).
- Reg2In  in  WIDTH  operand B.
- ImmIn  in  WIDTH  immediate / extended instruction word.
- AluSel  in  4  ALU operation select.
- AluSrc  in  1  1 = operand B comes from ImmIn.
- Branch  in  1  instruction is a jump.
- BrCond  in  2  jump condition: 00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- SetC  in  1  force C=1.
- ClrC  in  1  force C=0.
- MRIn, MWIn, MTRIn, RWIn  in  1 each  memory/writeback controls, passed through.
- RdstIn  in  3  destination register, passed through.
- FlushNumIn  in  2  flush tag from the previous stage.
- IntSave  in  1  pulse: copy CCR into the shadow CCR.
- RtiRestore  in  1  pulse: copy the shadow CCR into CCR.
- AluResOut  out  WIDTH  registered ALU result.
- StoreDataOut  out  WIDTH  registered Reg2In, used as store data.
- MROut, MWOut, MTROut, RWOut  out  1 each  registered controls.
- RdstOut  out  3  registered destination register.
- FlushNumOut  out  2  registered flush tag.
- CCROut  out  3  live CCR: {C, N, Z}.
- JumpTaken  out  1  combinational; taken jump this cycle.
- JumpTarget  out  WIDTH  combinational; equals Reg1In.

Behaviour:
- Operand selection: B = AluSrc ? ImmIn : Reg2In.
- AluSel encoding:
  - 0000 pass A; 0001 NOT A; 0010 A+1; 0011 A-1; 0100 A+B; 0101 A-B; 0110 A&B; 0111 A|B.
  - 1000 A<<ImmIn[SHAMT_W-1:0]; 1001 A>>ImmIn[SHAMT_W-1:0] (logical); 1010 pass B.
  - 1011 through 1111 pass A, with no flag update.
- Arithmetic is WIDTH+1 bits wide; C is the carry out (bit WIDTH).
  - Subtraction: C=1 on borrow (A<B unsigned).
  - DEC: C=1 when A==0.
  - INC: C=1 when A==FFFF.
  - Shifts: C = last bit shifted out; shift amount 0 leaves C unchanged.
- Flag updates:
  - Z and N are updated by ops 0001 through 1001. Z = (result==0), N = result[WIDTH-1].
  - C is updated by 0010 through 0101, 1000 and 1001. AND, OR, NOT keep C.
  - Pass ops (0000, 1010) and any cycle with Branch=1 update no flags from the ALU.
- SetC / ClrC override the ALU C in the same edge. If both are 1, ClrC wins.
- Jump resolution:
  - JumpTaken = Branch & (BrCond==11 | selected flag==1).
  - A taken conditional jump clears its tested flag at the next negedge. JMP clears nothing.
- Shadow CCR:
  - IntSave copies the current CCR (pre-update value) into the shadow.
  - RtiRestore loads the shadow into CCR, overriding every other flag source that edge.
  - IntSave and RtiRestore together: restore wins; the shadow is also written with the old CCR.
- EM boundary: at each negedge, all *Out buffers capture the current-cycle values. Latency is 1 negedge from input to output.
- Flush: when FlushNumIn != 0, RWOut and MWOut are forced to 0 and no flags update. The remaining fields still pass through.
- Reset: every registered output, CCR and shadow CCR = 0. Reset asserted mid-operation wins over any in-flight edge. First capture happens at the first negedge after deassertion.

Test Plan:
- ADD 7FFF+0001, AluSrc=0 -> AluResOut=8000, CCR={C0,N1,Z0} after one negedge.
- SUB 0003-0005 -> AluResOut=FFFE, C=1, N=1, Z=0. Then AND FFFE&0000 -> Z=1, N=0, C stays 1.
- With Z=1: Branch=1, BrCond=00, Reg1In=0040 -> JumpTaken=1, JumpTarget=0040, Z=0 after the edge. Repeat with Z=0 -> JumpTaken=0.
- SetC=ClrC=1 alongside ADD FFFF+0001 -> C=0, Z=1.
- IntSave with CCR=101, then NOT 0000 (N=1, Z=0), then RtiRestore -> CCR returns to 101.
- FlushNumIn=01 with RWIn=MWIn=1 -> RWOut=MWOut=0, CCR unchanged. Drop Rst mid-run -> all outputs 0 immediately, before any clock edge.

Source files
------------

// File: rtl/execute_stage_if.sv
// Decode/execute bundle into the execute stage and the execute/memory bundle out of it.
// The master side is the producer of the decoded bundle; the slave side is the execute stage.
interface execute_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] Reg1In;
    logic [WIDTH-1:0] Reg2In;
    logic [WIDTH-1:0] ImmIn;
    logic [3:0]       AluSel;
    logic             AluSrc;
    logic             Branch;
    logic [1:0]       BrCond;
    logic             SetC;
    logic             ClrC;
    logic             MRIn;
    logic             MWIn;
    logic             MTRIn;
    logic             RWIn;
    logic [2:0]       RdstIn;
    logic [1:0]       FlushNumIn;
    logic             IntSave;
    logic             RtiRestore;

    logic [WIDTH-1:0] AluResOut;
    logic [WIDTH-1:0] StoreDataOut;
    logic             MROut;
    logic             MWOut;
    logic             MTROut;
    logic             RWOut;
    logic [2:0]       RdstOut;
    logic [1:0]       FlushNumOut;
    logic [2:0]       CCROut;
    logic             JumpTaken;
    logic [WIDTH-1:0] JumpTarget;

    modport master (
        output Reg1In, Reg2In, ImmIn, AluSel, AluSrc, Branch, BrCond, SetC, ClrC,
               MRIn, MWIn, MTRIn, RWIn, RdstIn, FlushNumIn, IntSave, RtiRestore,
        input  AluResOut, StoreDataOut, MROut, MWOut, MTROut, RWOut, RdstOut,
               FlushNumOut, CCROut, JumpTaken, JumpTarget
    );

    modport slave (
        input  Reg1In, Reg2In, ImmIn, AluSel, AluSrc, Branch, BrCond, SetC, ClrC,
               MRIn, MWIn, MTRIn, RWIn, RdstIn, FlushNumIn, IntSave, RtiRestore,
        output AluResOut, StoreDataOut, MROut, MWOut, MTROut, RWOut, RdstOut,
               FlushNumOut, CCROut, JumpTaken, JumpTarget
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, condition-code register with interrupt shadow, jump resolution,
// and the execute/memory boundary registers, all updated on the falling clock edge.
module execute_stage #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    execute_stage_if.slave    bus
);
    localparam int CB = 2;  // CCR bit positions: {C, N, Z}
    localparam int NB = 1;
    localparam int ZB = 0;

    logic [WIDTH-1:0]   alu_res_q, store_data_q;
    logic               mr_q, mw_q, mtr_q, rw_q;
    logic [2:0]         rdst_q;
    logic [1:0]         flush_num_q;
    logic [2:0]         ccr_q, ccr_d;
    logic [2:0]         shadow_q, shadow_d;

    logic [WIDTH-1:0]   op_a, op_b, alu_res;
    logic [WIDTH:0]     arith, shl_w, shr_w;
    logic [SHAMT_W-1:0] shamt;
    logic               alu_c, zn_upd, c_upd;
    logic               flag_sel, jump_taken, live;

    always_comb begin
        op_a   = bus.Reg1In;
        op_b   = bus.AluSrc ? bus.ImmIn : bus.Reg2In;
        shamt  = bus.ImmIn[SHAMT_W-1:0];
        // Extra bit on each side of the shifters catches the last bit shifted out.
        shl_w  = {1'b0, op_a} << shamt;
        shr_w  = {op_a, 1'b0} >> shamt;
        arith  = '0;
        alu_res = op_a;
        alu_c  = ccr_q[CB];
        zn_upd = 1'b0;
        c_upd  = 1'b0;
        case (bus.AluSel)
            4'b0001: begin
                alu_res = ~op_a;
                zn_upd  = 1'b1;
            end
            4'b0010: begin
                arith   = {1'b0, op_a} + (WIDTH+1)'(1);
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                zn_upd  = 1'b1;
                c_upd   = 1'b1;
            end
            4'b0011: begin
                arith   = {1'b0, op_a} - (WIDTH+1)'(1);
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                zn_upd  = 1'b1;
                c_upd   = 1'b1;
            end
            4'b0100: begin
                arith   = {1'b0, op_a} + {1'b0, op_b};
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                zn_upd  = 1'b1;
                c_upd   = 1'b1;
            end
            4'b0101: begin
                arith   = {1'b0, op_a} - {1'b0, op_b};
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                zn_upd  = 1'b1;
                c_upd   = 1'b1;
            end
            4'b0110: begin
                alu_res = op_a & op_b;
                zn_upd  = 1'b1;
            end
            4'b0111: begin
                alu_res = op_a | op_b;
                zn_upd  = 1'b1;
            end
            4'b1000: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = (shamt != '0) ? shl_w[WIDTH] : ccr_q[CB];
                zn_upd  = 1'b1;
                c_upd   = 1'b1;
            end
            4'b1001: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = (shamt != '0) ? shr_w[0] : ccr_q[CB];
                zn_upd  = 1'b1;
                c_upd   = 1'b1;
            end
            4'b1010: alu_res = op_b;
            default: alu_res = op_a;
        endcase
    end

    always_comb begin
        case (bus.BrCond)
            2'b00:   flag_sel = ccr_q[ZB];
            2'b01:   flag_sel = ccr_q[NB];
            2'b10:   flag_sel = ccr_q[CB];
            default: flag_sel = 1'b1;
        endcase
        jump_taken = bus.Branch & flag_sel;
        live       = (bus.FlushNumIn == 2'b00);

        ccr_d    = ccr_q;
        shadow_d = bus.IntSave ? ccr_q : shadow_q;
        // A flushed slot is a squashed instruction: it must not touch the flags.
        if (live) begin
            if (!bus.Branch && zn_upd) begin
                ccr_d[ZB] = (alu_res == '0);
                ccr_d[NB] = alu_res[WIDTH-1];
            end
            if (!bus.Branch && c_upd) begin
                ccr_d[CB] = alu_c;
            end
            if (bus.SetC) ccr_d[CB] = 1'b1;
            if (bus.ClrC) ccr_d[CB] = 1'b0;
            if (jump_taken) begin
                case (bus.BrCond)
                    2'b00:   ccr_d[ZB] = 1'b0;
                    2'b01:   ccr_d[NB] = 1'b0;
                    2'b10:   ccr_d[CB] = 1'b0;
                    default: ;
                endcase
            end
        end
        if (bus.RtiRestore) ccr_d = shadow_q;
    end

    always_ff @(negedge Clk or negedge Rst) begin
        if (!Rst) begin
            alu_res_q    <= '0;
            store_data_q <= '0;
            mr_q         <= 1'b0;
            mw_q         <= 1'b0;
            mtr_q        <= 1'b0;
            rw_q         <= 1'b0;
            rdst_q       <= '0;
            flush_num_q  <= '0;
            ccr_q        <= '0;
            shadow_q     <= '0;
        end else begin
            alu_res_q    <= alu_res;
            store_data_q <= bus.Reg2In;
            mr_q         <= bus.MRIn;
            mw_q         <= bus.MWIn & live;
            mtr_q        <= bus.MTRIn;
            rw_q         <= bus.RWIn & live;
            rdst_q       <= bus.RdstIn;
            flush_num_q  <= bus.FlushNumIn;
            ccr_q        <= ccr_d;
            shadow_q     <= shadow_d;
        end
    end

    assign bus.AluResOut    = alu_res_q;
    assign bus.StoreDataOut = store_data_q;
    assign bus.MROut        = mr_q;
    assign bus.MWOut        = mw_q;
    assign bus.MTROut       = mtr_q;
    assign bus.RWOut        = rw_q;
    assign bus.RdstOut      = rdst_q;
    assign bus.FlushNumOut  = flush_num_q;
    assign bus.CCROut       = ccr_q;
    assign bus.JumpTaken    = jump_taken;
    assign bus.JumpTarget   = bus.Reg1In;
endmodule
